// File: rtl/feature_load_scheduler_pkg.sv
// feature_load_scheduler_pkg: shared state encoding and default sizing for the feature load scheduler
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif
package feature_load_scheduler_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RST_WAIT,
    S_REQ,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_e;
  localparam int BURST_LEN_DEF = 16;
  localparam int PREFILL_WORDS_DEF = 64;
  localparam int RST_WAIT_DEF = 16;
  localparam int BYTES_PER_BEAT = `MEM_DATA_WIDTH / 8;
endpackage

// File: rtl/feature_load_scheduler_addr_gen.sv
// burst_addr_gen: per-patch remaining/issued/written counters with next burst address and length
module burst_addr_gen
  import feature_load_scheduler_pkg::*;
#(
  parameter int AW  = 32,
  parameter int BL  = BURST_LEN_DEF,
  parameter int BPB = BYTES_PER_BEAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          issue,
  input  logic          beat,
  input  logic [17:0]   words,
  input  logic [AW-1:0] base,
  input  logic [7:0]    len,
  output logic [17:0]   rem,
  output logic [17:0]   wr_next,
  output logic [AW-1:0] next_addr,
  output logic [7:0]    next_len
);
  logic [17:0] rem_q, rem_d, iss_q, iss_d, wr_q, wr_d;
  logic [AW-1:0] base_q, base_d;
  always_comb begin
    rem_d  = init ? words : issue ? rem_q - 18'(len) : rem_q;
    iss_d  = init ? '0 : issue ? iss_q + 18'(len) : iss_q;
    wr_d   = init ? '0 : wr_q + 18'(beat);
    base_d = init ? base : base_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      iss_q  <= '0;
      wr_q   <= '0;
      base_q <= '0;
    end else begin
      rem_q  <= rem_d;
      iss_q  <= iss_d;
      wr_q   <= wr_d;
      base_q <= base_d;
    end
  end
  assign rem       = rem_q;
  assign wr_next   = wr_d;
  assign next_addr = base_q + AW'(iss_q) * AW'(BPB);
  assign next_len  = rem_q < 18'(BL) ? rem_q[7:0] : 8'(BL);
endmodule

// File: rtl/feature_load_scheduler.sv
// feature_load_scheduler: sequences one feature_buffer load pass from layer command to layer completion
module feature_load_scheduler
  import feature_load_scheduler_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH,
  parameter int BURST_LEN      = BURST_LEN_DEF,
  parameter int PREFILL_WORDS  = PREFILL_WORDS_DEF,
  parameter int RST_WAIT       = RST_WAIT_DEF
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic                      layer_start,
  input  logic [9:0]                cfg_row_size,
  input  logic [9:0]                cfg_col_size,
  input  logic                      cfg_double_patch,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr_1,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_base_addr_2,
  output logic                      layer_busy,
  output logic                      layer_done,
  output logic                      mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [7:0]                mem_rd_len,
  input  logic                      mem_rd_ack,
  input  logic                      mem_rd_data_valid,
  output logic                      load_feature_begin,
  output logic                      compute_begin,
  input  logic                      compute_finish,
  output logic                      feature_buffer_1_valid,
  output logic                      feature_buffer_2_valid,
  input  logic                      feature_buffer_1_ready,
  input  logic                      feature_buffer_2_ready,
  output logic                      feature_double_patch
);
  localparam int BPB = MEM_DATA_WIDTH / 8;
  state_e state_q, state_d;
  logic dbl_q, dbl_d, p_q, p_d, fin_q, fin_d, cbf_q, cbf_d, req_q, req_d;
  logic busy_q, busy_d, done_q, done_d, lfb_q, lfb_d, cb_q, cb_d;
  logic [7:0] beats_q, beats_d, len_q, len_d, wait_q, wait_d;
  logic [17:0] words_q, words_d, words_in, target;
  logic [19:0] pix;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [17:0] rem [2];
  logic [17:0] wr_next [2];
  logic [MEM_ADDR_WIDTH-1:0] next_addr [2];
  logic [7:0] next_len [2];
  logic [1:0] rem_nz, rdy, issue, beat_w;
  logic init, zero, last, launch, pref, sel, rdy_all, pre_ok, issue_any, beat_any, fin_now;
  assign pix       = 20'(cfg_row_size) * 20'(cfg_col_size);
  assign words_in  = 18'((pix + 20'd3) >> 2);
  assign zero      = cfg_row_size == 10'd0 || cfg_col_size == 10'd0;
  assign init      = state_q == S_IDLE && layer_start;
  assign rdy       = {feature_buffer_2_ready, feature_buffer_1_ready};
  assign rdy_all   = rdy[0] && (!dbl_q || rdy[1]);
  assign rem_nz    = {rem[1] != 18'd0, rem[0] != 18'd0};
  assign issue_any = state_q == S_REQ && req_q && mem_rd_ack;
  assign beat_any  = state_q == S_DATA && mem_rd_data_valid;
  assign last      = beat_any && beats_q == 8'd1;
  assign launch    = (state_q == S_REQ && !req_q) || (last && |rem_nz);
  assign pref      = state_q == S_DATA ? dbl_q & ~p_q : p_q;
  assign sel       = rem_nz[pref] ? pref : ~pref;
  assign target    = words_q < 18'(PREFILL_WORDS) ? words_q : 18'(PREFILL_WORDS);
  assign pre_ok    = wr_next[0] >= target && (!dbl_q || wr_next[1] >= target);
  assign fin_now   = fin_q || compute_finish;
  for (genvar i = 0; i < 2; i++) begin : g_patch
    assign issue[i]  = issue_any && p_q == 1'(i);
    assign beat_w[i] = beat_any && p_q == 1'(i);
    burst_addr_gen #(.AW(MEM_ADDR_WIDTH), .BL(BURST_LEN), .BPB(BPB)) u_gen (
      .clk       (system_clk),
      .rst_n     (rst_n),
      .init      (init),
      .issue     (issue[i]),
      .beat      (beat_w[i]),
      .words     ((i == 0 || cfg_double_patch) ? words_in : 18'd0),
      .base      (i == 0 ? cfg_base_addr_1 : cfg_base_addr_2),
      .len       (len_q),
      .rem       (rem[i]),
      .wr_next   (wr_next[i]),
      .next_addr (next_addr[i]),
      .next_len  (next_len[i])
    );
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     state_d = layer_start ? (zero ? S_DONE : S_RST) : S_IDLE;
      S_RST:      state_d = S_RST_WAIT;
      S_RST_WAIT: state_d = wait_q == 8'(RST_WAIT - 1) && rdy_all ? S_REQ : S_RST_WAIT;
      S_REQ:      state_d = issue_any ? S_DATA : S_REQ;
      S_DATA:     state_d = last ? (|rem_nz ? S_REQ : S_DRAIN) : S_DATA;
      S_DRAIN:    state_d = fin_now ? S_DONE : S_DRAIN;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    dbl_d   = init ? cfg_double_patch : dbl_q;
    words_d = init ? words_in : words_q;
    p_d     = init ? 1'b0 : launch ? sel : p_q;
    fin_d   = init ? 1'b0 : fin_q | (compute_finish && state_q != S_IDLE);
    cb_d    = state_q == S_DATA && !cbf_q && pre_ok;
    cbf_d   = init ? 1'b0 : cbf_q | cb_d;
    req_d   = launch ? rdy[sel] : req_q && !mem_rd_ack;
    addr_d  = launch && rdy[sel] ? next_addr[sel] : addr_q;
    len_d   = launch && rdy[sel] ? next_len[sel] : len_q;
    beats_d = issue_any ? len_q : beat_any ? beats_q - 8'd1 : beats_q;
    wait_d  = state_q != S_RST_WAIT ? 8'd0 : wait_q == 8'(RST_WAIT - 1) ? wait_q : wait_q + 8'd1;
    done_d  = (state_q == S_DRAIN && fin_now) || (state_q == S_DONE && !done_q);
    busy_d  = init ? 1'b1 : done_d ? 1'b0 : busy_q;
    lfb_d   = init && !zero;
  end
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dbl_q   <= 1'b0;
      words_q <= '0;
      p_q     <= 1'b0;
      fin_q   <= 1'b0;
      cb_q    <= 1'b0;
      cbf_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beats_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      lfb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dbl_q   <= dbl_d;
      words_q <= words_d;
      p_q     <= p_d;
      fin_q   <= fin_d;
      cb_q    <= cb_d;
      cbf_q   <= cbf_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      lfb_q   <= lfb_d;
    end
  end
  assign layer_busy             = busy_q;
  assign layer_done             = done_q;
  assign mem_rd_req             = req_q;
  assign mem_rd_addr            = addr_q;
  assign mem_rd_len             = len_q;
  assign load_feature_begin     = lfb_q;
  assign compute_begin          = cb_q;
  assign feature_buffer_1_valid = beat_w[0];
  assign feature_buffer_2_valid = beat_w[1];
  assign feature_double_patch   = dbl_q;
endmodule

// File: tb/tb_feature_load_scheduler.sv
// tb_feature_load_scheduler: scoreboard bench with directed layer commands for feature_load_scheduler
module tb_feature_load_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, layer_start = 1'b0, dbl = 1'b0;
  logic ack = 1'b0, dv = 1'b0, cf = 1'b0, r1 = 1'b1, r2 = 1'b1;
  logic [9:0] row = '0, col = '0;
  logic [31:0] b1 = '0, b2 = '0, addr;
  logic [7:0] len;
  logic busy, done, req, lfb, cb, v1, v2, fdbl;
  logic [1:0] rdy_req = 2'b11;
  logic req_prev = 1'b0;
  int cmp_n = 0, mis_n = 0, cyc = 0;
  int beats_n = 0, cb_n = 0, done_n = 0, lfb_n = 0, req_n = 0;
  int cb_cyc = 0, done_cyc = 0, last_cyc = 0, cb_beats = 0, lfb_cyc = 0, req_cyc = 0, start_cyc = 0, fin_cyc = 0;
  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic p;} req_t;
  req_t req_q[$];
  logic beat_q[$];
  req_t exp_r;

  feature_load_scheduler dut (
    .system_clk(clk), .rst_n(rst_n), .layer_start(layer_start),
    .cfg_row_size(row), .cfg_col_size(col), .cfg_double_patch(dbl),
    .cfg_base_addr_1(b1), .cfg_base_addr_2(b2),
    .layer_busy(busy), .layer_done(done),
    .mem_rd_req(req), .mem_rd_addr(addr), .mem_rd_len(len), .mem_rd_ack(ack),
    .mem_rd_data_valid(dv), .load_feature_begin(lfb), .compute_begin(cb),
    .compute_finish(cf), .feature_buffer_1_valid(v1), .feature_buffer_2_valid(v2),
    .feature_buffer_1_ready(r1), .feature_buffer_2_ready(r2),
    .feature_double_patch(fdbl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!req) rdy_req <= {r2, r1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (v1 || v2) begin
        beats_n++;
        last_cyc = cyc;
        check("beat_patch", {v2, v1}, beat_q.size() == 0 ? 2'b00 : (beat_q.pop_front() ? 2'b10 : 2'b01));
      end
      if (cb) begin cb_n++; cb_cyc = cyc; cb_beats = beats_n; end
      if (done) begin done_n++; done_cyc = cyc; end
      if (lfb) begin lfb_n++; lfb_cyc = cyc; end
      if (req && !req_prev) req_cyc = cyc;
    end
    req_prev = req;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && req) begin
      req_n++;
      exp_r = req_q.size() != 0 ? req_q.pop_front() : '0;
      check("req_addr", addr, exp_r.addr);
      check("req_len", len, exp_r.len);
      check("req_ready", exp_r.p ? rdy_req[1] : rdy_req[0], 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      for (int i = 0; i < int'(len) && rst_n; i++) begin
        dv = 1'b1;
        @(negedge clk);
      end
      dv = 1'b0;
    end
  end

  task automatic start_cmd(input int r, input int c, input bit d, input logic [31:0] a1, input logic [31:0] a2);
    int words, p, l;
    int rem [2];
    int iss [2];
    words = (r * c + 3) / 4;
    rem[0] = words;
    rem[1] = d ? words : 0;
    iss[0] = 0;
    iss[1] = 0;
    p = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[p] == 0) p = 1 - p;
      l = rem[p] < 16 ? rem[p] : 16;
      req_q.push_back(req_t'{addr: (p != 0 ? a2 : a1) + 32'(iss[p] * 64), len: 8'(l), p: p[0]});
      repeat (l) beat_q.push_back(p[0]);
      rem[p] -= l;
      iss[p] += l;
      if (d) p = 1 - p;
    end
    @(negedge clk);
    row = 10'(r); col = 10'(c); dbl = d; b1 = a1; b2 = a2;
    layer_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    layer_start = 1'b0;
  endtask

  task automatic wait_cb(input int n0, input string name);
    int t = 0;
    while (cb_n == n0 && t < 3000) begin @(negedge clk); #4; t++; end
    check(name, cb_n, n0 + 1);
  endtask

  task automatic wait_done(input int n0, input string name);
    int t = 0;
    while (done_n == n0 && t < 3000) begin @(negedge clk); #4; t++; end
    check(name, done_n, n0 + 1);
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    cf = 1'b1;
    fin_cyc = cyc;
    @(negedge clk);
    cf = 1'b0;
  endtask

  initial begin
    int n0, c0, bb0, b40, q0, l0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, req, lfb, cb, v1, v2, fdbl, addr, len}, '0);
    rst_n = 1'b1;

    n0 = done_n; c0 = cb_n; bb0 = beats_n;
    start_cmd(8, 8, 0, 32'h1000, 32'h0);
    wait_cb(c0, "t1_cb_seen");
    check("t1_cb_after_16", cb_beats - bb0, 16);
    check("t1_lfb_latency", lfb_cyc - start_cyc, 1);
    check("t1_req_latency_min", (req_cyc - start_cyc) >= 18, 1);
    pulse_finish();
    wait_done(n0, "t1_done_seen");
    check("t1_done_latency", done_cyc - fin_cyc, 1);
    check("t1_queues_empty", req_q.size() + beat_q.size(), 0);
    @(negedge clk); #4;
    check("t1_busy_low", busy, 0);

    n0 = done_n; c0 = cb_n; bb0 = beats_n;
    start_cmd(16, 16, 1, 32'h10000, 32'h20000);
    wait_cb(c0, "t2_cb_seen");
    check("t2_cb_after_8_bursts", cb_beats - bb0, 128);
    check("t2_double_flag", fdbl, 1);
    pulse_finish();
    wait_done(n0, "t2_done_seen");
    check("t2_queues_empty", req_q.size() + beat_q.size(), 0);

    n0 = done_n; c0 = cb_n; bb0 = beats_n;
    start_cmd(5, 3, 0, 32'h3000, 32'h0);
    wait_cb(c0, "t3_cb_seen");
    check("t3_cb_after_4", cb_beats - bb0, 4);
    pulse_finish();
    wait_done(n0, "t3_done_seen");
    check("t3_queues_empty", req_q.size() + beat_q.size(), 0);

    n0 = done_n; c0 = cb_n; bb0 = beats_n;
    start_cmd(16, 16, 1, 32'h40000, 32'h50000);
    repeat (24) @(negedge clk);
    r2 = 1'b0;
    repeat (40) @(negedge clk);
    b40 = beats_n;
    repeat (10) @(negedge clk);
    check("t4_stalled", beats_n - b40, 0);
    r2 = 1'b1;
    wait_cb(c0, "t4_cb_seen");
    check("t4_total_beats", cb_beats - bb0, 128);
    pulse_finish();
    wait_done(n0, "t4_done_seen");
    check("t4_queues_empty", req_q.size() + beat_q.size(), 0);

    n0 = done_n; c0 = cb_n;
    start_cmd(8, 8, 0, 32'h5000, 32'h0);
    repeat (5) @(negedge clk);
    pulse_finish();
    wait_done(n0, "t5_done_seen");
    check("t5_done_after_last_beat", done_cyc - last_cyc, 2);
    check("t5_cb_before_done", cb_n == c0 + 1 && done_cyc > cb_cyc, 1);
    check("t5_queues_empty", req_q.size() + beat_q.size(), 0);

    n0 = done_n; c0 = cb_n; q0 = req_n; l0 = lfb_n;
    start_cmd(0, 12, 0, 32'h6000, 32'h0);
    wait_done(n0, "t5z_done_seen");
    check("t5z_done_latency", done_cyc - start_cyc, 2);
    check("t5z_no_req_lfb_cb", {32'(req_n - q0), 16'(lfb_n - l0), 16'(cb_n - c0)}, 64'd0);

    bb0 = beats_n;
    start_cmd(16, 16, 1, 32'h60000, 32'h70000);
    for (int t = 0; t < 500 && beats_n < bb0 + 20; t++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_q.delete();
    beat_q.delete();
    #1;
    check("t6_reset_outputs", {busy, done, req, lfb, cb, v1, v2, fdbl, addr, len}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    n0 = done_n; c0 = cb_n; bb0 = beats_n;
    start_cmd(8, 8, 0, 32'h8000, 32'h0);
    repeat (30) @(negedge clk);
    row = 10'd0;
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    wait_cb(c0, "t6_cb_seen");
    check("t6_cb_after_16", cb_beats - bb0, 16);
    pulse_finish();
    wait_done(n0, "t6_done_seen");
    repeat (5) @(negedge clk);
    #4;
    check("t6_single_done", done_n - n0, 1);
    check("t6_queues_empty", req_q.size() + beat_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end
endmodule
